// File: rtl/mc_controller_ext_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller is the master: it samples IR fields and flags, and drives every strobe.
interface mc_controller_ext_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;

    logic       pcen;
    logic       memwrite;
    logic       memreq;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, memready,
        output pcen, memwrite, memreq, irwrite, regwrite, alusrca, iord,
               memtoreg, regdst, alusrcb, pcsrc, alucontrol, illegal, state
    );

    modport slave (
        output op, funct, zero, memready,
        input  pcen, memwrite, memreq, irwrite, regwrite, alusrca, iord,
               memtoreg, regdst, alusrcb, pcsrc, alucontrol, illegal, state
    );
endinterface

// File: rtl/mc_controller_ext.sv
// Multicycle MIPS control unit: Moore main FSM, ALU decoder and PC-enable logic,
// with bne/addi/j extensions, optional memory wait states and illegal-opcode reporting.
//
// state   | meaning
// --------+------------------------------------------------
// FETCH   | read instruction at PC, PC <= PC+4 (waits on memready)
// DECODE  | register read, branch target into ALUOut
// MEMADR  | effective address for lw/sw
// MEMRD   | data read (waits on memready)
// MEMWB   | load write-back to rt
// MEMWR   | data write (waits on memready)
// EXECUTE | R-type ALU operation
// ALUWB   | R-type write-back to rd
// BEQ     | PC <= ALUOut when zero
// ADDIEX  | rs + SignImm
// ADDIWB  | addi write-back to rt
// JUMP    | PC <= jump target
// BNE     | PC <= ALUOut when not zero
module mc_controller_ext #(
    parameter bit MEM_WAIT = 1'b0,
    parameter bit EN_BNE   = 1'b1,
    parameter bit EN_ADDI  = 1'b1,
    parameter bit EN_JUMP  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    mc_controller_ext_if.master    bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_BNE     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef struct packed {
        logic       memreq;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       branch;
        logic       branchne;
        logic       jump;
        logic       fetch;
    } ctl_t;

    // Per-state Moore outputs; unreachable codes fall through to all-zero.
    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memreq  = 1'b1;
                c.alusrcb = 2'b01;
                c.fetch   = 1'b1;
            end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c.memreq = 1'b1;
                c.iord   = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.memreq   = 1'b1;
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BEQ: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc = 2'b10;
                c.jump  = 1'b1;
            end
            S_BNE: begin
                c.alusrca  = 1'b1;
                c.aluop    = 2'b01;
                c.pcsrc    = 2'b01;
                c.branchne = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     state_q;
    state_t     state_n;
    ctl_t       ctl_q;
    logic       mr_eff;
    logic       op_legal;
    logic       illegal_c;
    logic       pcwrite_c;
    logic       pcen_c;
    logic [2:0] aluctl_c;

    assign mr_eff = MEM_WAIT ? bus.memready : 1'b1;

    always_comb begin
        op_legal = 1'b0;
        case (bus.op)
            OP_R, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
            OP_BNE:                     op_legal = EN_BNE;
            OP_ADDI:                    op_legal = EN_ADDI;
            OP_J:                       op_legal = EN_JUMP;
            default:                    op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_FETCH:   state_n = mr_eff ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_n = S_FETCH;
                if (op_legal) begin
                    case (bus.op)
                        OP_LW, OP_SW: state_n = S_MEMADR;
                        OP_R:         state_n = S_EXECUTE;
                        OP_BEQ:       state_n = S_BEQ;
                        OP_BNE:       state_n = S_BNE;
                        OP_ADDI:      state_n = S_ADDIEX;
                        OP_J:         state_n = S_JUMP;
                        default:      state_n = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  state_n = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_n = mr_eff ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_n = S_FETCH;
            S_MEMWR:   state_n = mr_eff ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_n = S_ALUWB;
            S_ALUWB:   state_n = S_FETCH;
            S_ADDIEX:  state_n = S_ADDIWB;
            S_ADDIWB:  state_n = S_FETCH;
            S_BEQ, S_BNE, S_JUMP: state_n = S_FETCH;
            default:   state_n = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state so both always agree.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctl_q   <= ctl_of(S_FETCH);
        end else begin
            state_q <= state_n;
            ctl_q   <= ctl_of(state_n);
        end
    end

    always_comb begin
        aluctl_c = 3'b010;
        case (ctl_q.aluop)
            2'b01:   aluctl_c = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100000: aluctl_c = 3'b010;
                    6'b100010: aluctl_c = 3'b110;
                    6'b100100: aluctl_c = 3'b000;
                    6'b100101: aluctl_c = 3'b001;
                    6'b101010: aluctl_c = 3'b111;
                    default:   aluctl_c = 3'b010;
                endcase
            end
            default: aluctl_c = 3'b010;
        endcase
    end

    assign illegal_c = (state_q == S_DECODE) && !op_legal;
    assign pcwrite_c = (ctl_q.fetch & mr_eff) | ctl_q.jump;
    assign pcen_c    = pcwrite_c | (ctl_q.branch & bus.zero) | (ctl_q.branchne & ~bus.zero);

    // Everything except the debug state is silenced while reset is held low.
    assign bus.pcen       = reset & pcen_c;
    assign bus.memwrite   = reset & ctl_q.memwrite;
    assign bus.memreq     = reset & ctl_q.memreq;
    assign bus.irwrite    = reset & ctl_q.fetch & mr_eff;
    assign bus.regwrite   = reset & ctl_q.regwrite;
    assign bus.alusrca    = reset & ctl_q.alusrca;
    assign bus.iord       = reset & ctl_q.iord;
    assign bus.memtoreg   = reset & ctl_q.memtoreg;
    assign bus.regdst     = reset & ctl_q.regdst;
    assign bus.alusrcb    = reset ? ctl_q.alusrcb : 2'b00;
    assign bus.pcsrc      = reset ? ctl_q.pcsrc : 2'b00;
    assign bus.alucontrol = reset ? aluctl_c : 3'b000;
    assign bus.illegal    = reset & illegal_c;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller_ext.sv
// Scoreboard bench for mc_controller_ext: dut_a waits on memready with all extensions,
// dut_b ignores memready and has bne disabled.
module tb_mc_controller_ext;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mr_a;
    logic       mr_b;

    always #5 clk = ~clk;

    mc_controller_ext_if ifa ();
    mc_controller_ext_if ifb ();

    assign ifa.op       = op;
    assign ifa.funct    = funct;
    assign ifa.zero     = zero;
    assign ifa.memready = mr_a;
    assign ifb.op       = op;
    assign ifb.funct    = funct;
    assign ifb.zero     = zero;
    assign ifb.memready = mr_b;

    mc_controller_ext #(.MEM_WAIT(1'b1), .EN_BNE(1'b1), .EN_ADDI(1'b1), .EN_JUMP(1'b1))
        dut_a (.clk(clk), .reset(rst), .bus(ifa.master));
    mc_controller_ext #(.MEM_WAIT(1'b0), .EN_BNE(1'b0), .EN_ADDI(1'b1), .EN_JUMP(1'b1))
        dut_b (.clk(clk), .reset(rst), .bus(ifb.master));

    typedef struct {
        int          d;
        logic [3:0]  st;
        logic [16:0] vec;
        string       tag;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input int d);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            OP_BNE:  return (d == 0);
            default: return 1'b0;
        endcase
    endfunction

    // Reference outputs from the state table:
    // {pcen,memwrite,memreq,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol,illegal}
    function automatic logic [16:0] exp_vec(input int d, input logic [3:0] s);
        logic pcen, mw, mreq, irw, rw, asa, iord, m2r, rdst, ill, mre;
        logic [1:0] asb, psrc;
        logic [2:0] actl;
        {pcen, mw, mreq, irw, rw, asa, iord, m2r, rdst, ill} = '0;
        asb  = 2'b00;
        psrc = 2'b00;
        actl = 3'b010;
        mre  = (d == 0) ? mr_a : 1'b1;
        if (!rst) return '0;
        case (s)
            4'd0:  begin mreq = 1; asb = 2'b01; irw = mre; pcen = mre; end
            4'd1:  begin asb = 2'b11; ill = !is_legal(d); end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mreq = 1; iord = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin mreq = 1; iord = 1; mw = 1; end
            4'd6: begin
                asa = 1;
                case (funct)
                    6'b100010: actl = 3'b110;
                    6'b100100: actl = 3'b000;
                    6'b100101: actl = 3'b001;
                    6'b101010: actl = 3'b111;
                    default:   actl = 3'b010;
                endcase
            end
            4'd7:  begin rdst = 1; rw = 1; end
            4'd8:  begin asa = 1; psrc = 2'b01; actl = 3'b110; pcen = zero; end
            4'd9:  begin asa = 1; asb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin psrc = 2'b10; pcen = 1; end
            4'd12: begin asa = 1; psrc = 2'b01; actl = 3'b110; pcen = ~zero; end
            default: ;
        endcase
        return {pcen, mw, mreq, irw, rw, asa, iord, m2r, rdst, asb, psrc, actl, ill};
    endfunction

    function automatic logic [16:0] obs(input int d);
        if (d == 0)
            return {ifa.pcen, ifa.memwrite, ifa.memreq, ifa.irwrite, ifa.regwrite, ifa.alusrca,
                    ifa.iord, ifa.memtoreg, ifa.regdst, ifa.alusrcb, ifa.pcsrc, ifa.alucontrol,
                    ifa.illegal};
        return {ifb.pcen, ifb.memwrite, ifb.memreq, ifb.irwrite, ifb.regwrite, ifb.alusrca,
                ifb.iord, ifb.memtoreg, ifb.regdst, ifb.alusrcb, ifb.pcsrc, ifb.alucontrol,
                ifb.illegal};
    endfunction

    function automatic logic [3:0] obs_state(input int d);
        return (d == 0) ? ifa.state : ifb.state;
    endfunction

    // Push expectation for the current cycle, then advance to just after the next edge.
    task automatic step(input int d, input logic [3:0] s, input string tag);
        sb_entry_t e;
        e.d   = d;
        e.st  = s;
        e.vec = exp_vec(d, s);
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(d, 4'd0, "reset");
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        sb_entry_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_state"}, 32'(obs_state(e.d)), 32'(e.st));
            chk({e.tag, "_outs"}, 32'(obs(e.d)), 32'(e.vec));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b0;
        op    = OP_R;
        funct = 6'b100000;
        zero  = 1'b0;
        mr_a  = 1'b1;
        mr_b  = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // lw, no wait states: 0,1,2,3,4,0
        do_reset(1);
        op = OP_LW;
        #1 chk("lw_fetch_vec15",
               32'({ifb.pcen, ifb.memwrite, ifb.irwrite, ifb.regwrite, ifb.alusrca, ifb.iord,
                    ifb.memtoreg, ifb.regdst, ifb.alusrcb, ifb.pcsrc, ifb.alucontrol}),
               32'h5022);
        step(1, 4'd0, "lw_fetch");
        step(1, 4'd1, "lw_decode");
        step(1, 4'd2, "lw_memadr");
        step(1, 4'd3, "lw_memrd");
        step(1, 4'd4, "lw_memwb");
        step(1, 4'd0, "lw_done");

        // R-type sub then slt; memready low must be ignored when MEM_WAIT=0
        do_reset(1);
        mr_b  = 1'b0;
        op    = OP_R;
        funct = 6'b100010;
        step(1, 4'd0, "sub_fetch");
        step(1, 4'd1, "sub_decode");
        #1 chk("sub_alucontrol", 32'(ifb.alucontrol), 32'h6);
        step(1, 4'd6, "sub_exec");
        step(1, 4'd7, "sub_aluwb");
        funct = 6'b101010;
        step(1, 4'd0, "slt_fetch");
        step(1, 4'd1, "slt_decode");
        #1 chk("slt_alucontrol", 32'(ifb.alucontrol), 32'h7);
        step(1, 4'd6, "slt_exec");
        step(1, 4'd7, "slt_aluwb");
        funct = 6'b100100;
        step(1, 4'd0, "and_fetch");
        step(1, 4'd1, "and_decode");
        step(1, 4'd6, "and_exec");
        step(1, 4'd7, "and_aluwb");
        step(1, 4'd0, "r_done");
        mr_b = 1'b1;

        // beq taken and not taken
        do_reset(1);
        op   = OP_BEQ;
        zero = 1'b1;
        step(1, 4'd0, "beq1_fetch");
        step(1, 4'd1, "beq1_decode");
        step(1, 4'd8, "beq1_taken");
        zero = 1'b0;
        step(1, 4'd0, "beq0_fetch");
        step(1, 4'd1, "beq0_decode");
        step(1, 4'd8, "beq0_nottaken");
        step(1, 4'd0, "beq_done");

        // bne taken and not taken
        do_reset(0);
        op   = OP_BNE;
        zero = 1'b0;
        step(0, 4'd0, "bne0_fetch");
        step(0, 4'd1, "bne0_decode");
        step(0, 4'd12, "bne0_taken");
        zero = 1'b1;
        step(0, 4'd0, "bne1_fetch");
        step(0, 4'd1, "bne1_decode");
        step(0, 4'd12, "bne1_nottaken");
        step(0, 4'd0, "bne_done");
        zero = 1'b0;

        // sw with 3 wait cycles in FETCH and 2 in MEMWR: 9 cycles
        do_reset(0);
        op   = OP_SW;
        mr_a = 1'b0;
        step(0, 4'd0, "sw_fetch_wait1");
        step(0, 4'd0, "sw_fetch_wait2");
        step(0, 4'd0, "sw_fetch_wait3");
        mr_a = 1'b1;
        step(0, 4'd0, "sw_fetch_go");
        step(0, 4'd1, "sw_decode");
        step(0, 4'd2, "sw_memadr");
        mr_a = 1'b0;
        step(0, 4'd5, "sw_memwr_wait1");
        step(0, 4'd5, "sw_memwr_wait2");
        mr_a = 1'b1;
        step(0, 4'd5, "sw_memwr_go");
        step(0, 4'd0, "sw_done");

        // addi
        do_reset(0);
        op = OP_ADDI;
        step(0, 4'd0, "addi_fetch");
        step(0, 4'd1, "addi_decode");
        step(0, 4'd9, "addi_ex");
        step(0, 4'd10, "addi_wb");
        step(0, 4'd0, "addi_done");

        // illegal opcode, and bne on the variant without bne
        do_reset(0);
        op = 6'b111111;
        step(0, 4'd0, "ill_fetch");
        step(0, 4'd1, "ill_decode");
        step(0, 4'd0, "ill_back");
        do_reset(1);
        op = OP_BNE;
        step(1, 4'd0, "nobne_fetch");
        step(1, 4'd1, "nobne_decode");
        step(1, 4'd0, "nobne_back");

        // reset during MEMRD, then a jump
        do_reset(0);
        op = OP_LW;
        step(0, 4'd0, "rlw_fetch");
        step(0, 4'd1, "rlw_decode");
        step(0, 4'd2, "rlw_memadr");
        rst = 1'b0;
        step(0, 4'd3, "rlw_memrd_in_reset");
        rst = 1'b1;
        op  = OP_J;
        step(0, 4'd0, "j_fetch");
        step(0, 4'd1, "j_decode");
        step(0, 4'd11, "j_jump");
        step(0, 4'd0, "j_done");

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
